// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with req/ack imem fetch, small FIFO to IF/ID, redirect flush with in-flight discard.
// Optional FETCH_PERF_EN adds saturating fetch/bubble counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
  localparam logic [1:0] LAST  = 2'(QUEUE_DEPTH - 1);
  localparam logic [2:0] DEPTH = 3'(QUEUE_DEPTH);
  state_t      state, state_nx;
  logic [31:0] fetch_pc, disc_addr;
  logic [31:0] q_instr [4];
  logic [31:0] q_pc4 [4];
  logic [1:0]  rd_ptr, wr_ptr;
  logic [2:0]  count, count_nx;
  logic        push, pop;
  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction
  assign push         = (state == REQ) && imem_ack && !redirect;
  assign pop          = out_valid && id_ready;
  assign count_nx     = redirect ? 3'd0 : count + {2'b0, push} - {2'b0, pop};
  assign out_valid    = (count != 3'd0);
  assign out_instr    = out_valid ? q_instr[rd_ptr] : 32'h0;
  assign out_pc_plus4 = out_valid ? q_pc4[rd_ptr] : 32'h0;
  assign imem_req     = (state != IDLE);
  // DISCARD keeps presenting the abandoned address until its ack drains it
  assign imem_addr    = (state == DISCARD) ? disc_addr : fetch_pc;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (redirect || count < DEPTH) ? REQ : IDLE;
      REQ:     state_nx = redirect ? (imem_ack ? REQ : DISCARD)
                                   : (imem_ack && !(count_nx < DEPTH)) ? IDLE : REQ;
      DISCARD: state_nx = imem_ack ? REQ : DISCARD;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      disc_addr <= RESET_PC;
      rd_ptr    <= 2'd0;
      wr_ptr    <= 2'd0;
      count     <= 3'd0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      if (redirect) begin
        fetch_pc <= redirect_pc & ~32'h3;
        rd_ptr   <= 2'd0;
        wr_ptr   <= 2'd0;
        if (state == REQ && !imem_ack) disc_addr <= fetch_pc;
      end else begin
        if (push) begin
          fetch_pc <= fetch_pc + 32'd4;
          wr_ptr   <= nxt(wr_ptr);
        end
        if (pop) rd_ptr <= nxt(rd_ptr);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc4[wr_ptr]   <= fetch_pc + 32'd4;
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt  <= 32'h0;
      perf_bubble_cnt <= 32'h0;
    end else begin
      if (push && perf_fetch_cnt != 32'hFFFF_FFFF) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (id_ready && !out_valid && perf_bubble_cnt != 32'hFFFF_FFFF) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table-driven bench for fetch_unit plus hand-written redirect/reset sequences.
module tb_fetch_unit;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic clk = 1'b0;
  logic rst_n;
  logic redirect, id_ready, ack_en;
  logic [31:0] redirect_pc;
  logic imem_req, imem_ack, out_valid;
  logic [31:0] imem_addr, imem_rdata, out_instr, out_pc_plus4;
  logic imem_req2, imem_ack2, out_valid2;
  logic [31:0] imem_addr2, imem_rdata2, out_instr2, out_pc_plus42;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_ack    = ack_en && imem_req;
  assign imem_rdata  = imem_addr ^ K;
  assign imem_ack2   = ack_en && imem_req2;
  assign imem_rdata2 = imem_addr2 ^ K;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_ready(id_ready), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc_plus4(out_pc_plus4)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .QUEUE_DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_ready(id_ready), .out_valid(out_valid2),
    .out_instr(out_instr2), .out_pc_plus4(out_pc_plus42)
  );

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        idr;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc4;
  } vec_t;
  vec_t v [16];

  function automatic vec_t mk(input logic rd, input logic [31:0] rpc, input logic idr,
                              input logic ack, input logic e_req, input logic [31:0] e_addr,
                              input logic e_val, input logic [31:0] e_pc4);
    vec_t r;
    r.rd = rd; r.rpc = rpc; r.idr = idr; r.ack = ack;
    r.e_req = e_req; r.e_addr = e_addr; r.e_val = e_val; r.e_pc4 = e_pc4;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // zero-wait fetch, 6-cycle stall, redirect coinciding with an ack
    v[0]  = mk(1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
    v[1]  = mk(1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h0,   1'b0, 32'h0);
    v[2]  = mk(1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h4,   1'b1, 32'h4);
    v[3]  = mk(1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h8,   1'b1, 32'h8);
    v[4]  = mk(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'hC,   1'b1, 32'hC);
    v[5]  = mk(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h10,  1'b1, 32'hC);
    v[6]  = mk(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h10,  1'b1, 32'hC);
    v[7]  = mk(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h10,  1'b1, 32'hC);
    v[8]  = mk(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h10,  1'b1, 32'hC);
    v[9]  = mk(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h10,  1'b1, 32'hC);
    v[10] = mk(1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h10,  1'b1, 32'hC);
    v[11] = mk(1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h10,  1'b1, 32'h10);
    v[12] = mk(1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h10,  1'b0, 32'h0);
    v[13] = mk(1'b1, 32'h201, 1'b1, 1'b1, 1'b1, 32'h14,  1'b1, 32'h14);
    v[14] = mk(1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    v[15] = mk(1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h204, 1'b1, 32'h204);

    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0; ack_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc4", out_pc_plus4, 32'h0);
    chk("rst_addr_hi", imem_addr2, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      redirect = v[i].rd; redirect_pc = v[i].rpc; id_ready = v[i].idr; ack_en = v[i].ack;
      chk($sformatf("req[%0d]", i), {31'h0, imem_req}, {31'h0, v[i].e_req});
      chk($sformatf("addr[%0d]", i), imem_addr, v[i].e_addr);
      chk($sformatf("valid[%0d]", i), {31'h0, out_valid}, {31'h0, v[i].e_val});
      chk($sformatf("pc4[%0d]", i), out_pc_plus4, v[i].e_pc4);
      chk($sformatf("instr[%0d]", i), out_instr, v[i].e_val ? ((v[i].e_pc4 - 32'd4) ^ K) : 32'h0);
      if (i == 1) chk("wrap_addr1", imem_addr2, 32'hFFFF_FFFC);
      if (i == 2) begin
        chk("wrap_addr2", imem_addr2, 32'h0);
        chk("wrap_valid", {31'h0, out_valid2}, 32'h1);
        chk("wrap_pc4", out_pc_plus42, 32'h0);
      end
      cyc();
    end

    // asynchronous reset while a request is outstanding
    redirect = 1'b0;
    chk("pre_rst_req", {31'h0, imem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'h0, imem_req}, 32'h0);
    chk("arst_valid", {31'h0, out_valid}, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    cyc();
    rst_n = 1'b1; ack_en = 1'b1; id_ready = 1'b1;
    cyc();
    chk("refetch_req", {31'h0, imem_req}, 32'h1);
    chk("refetch_addr", imem_addr, 32'h0);
    cyc();
    cyc();
    // hold the fetch of 0x8 for three cycles, then redirect while it waits
    chk("wait_addr0", imem_addr, 32'h8);
    ack_en = 1'b0;
    cyc();
    chk("wait_addr1", imem_addr, 32'h8);
    chk("wait_req1", {31'h0, imem_req}, 32'h1);
    cyc();
    chk("wait_addr2", imem_addr, 32'h8);
    redirect = 1'b1; redirect_pc = 32'h100;
    cyc();
    redirect = 1'b0;
    chk("disc_req", {31'h0, imem_req}, 32'h1);
    chk("disc_addr", imem_addr, 32'h8);
    chk("disc_valid", {31'h0, out_valid}, 32'h0);
    ack_en = 1'b1;
    cyc();
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_valid", {31'h0, out_valid}, 32'h0);
    cyc();
    chk("redir_out_valid", {31'h0, out_valid}, 32'h1);
    chk("redir_pc4", out_pc_plus4, 32'h104);
    chk("redir_instr", out_instr, 32'h100 ^ K);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
